// File: rtl/sgpr_busy_table.sv
// sgpr_busy_table: one busy bit per physical SGPR for the issue stage.
// Issues set multi-word ranges, retire channels clear them, and check lanes
// report (one cycle later) whether a range is free. WAW and spurious-retire
// protocol violations are latched as sticky error flags.
module sgpr_busy_table #(
  parameter int ADDR_W        = 9,
  parameter int MAX_LOG_WORDS = 2,
  parameter int NUM_RET       = 2,
  parameter int NUM_CHK       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [1:0]                issue_size,
  input  logic [NUM_RET-1:0]        ret_valid,
  input  logic [NUM_RET*ADDR_W-1:0] ret_addr,
  input  logic [NUM_RET*2-1:0]      ret_size,
  input  logic [NUM_CHK-1:0]        chk_valid,
  input  logic [NUM_CHK*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHK*2-1:0]      chk_size,
  output logic [NUM_CHK-1:0]        chk_rsp_valid,
  output logic [NUM_CHK-1:0]        chk_ready,
  output logic [ADDR_W:0]           busy_count,
  output logic                      err_waw,
  output logic                      err_ret
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [1:0]  SIZE_LIM = 2'(MAX_LOG_WORDS);

  // Oversized operands are treated as the largest legal size.
  function automatic logic [1:0] clamp_size(input logic [1:0] s);
    return (s > SIZE_LIM) ? SIZE_LIM : s;
  endfunction

  // Expand (addr, size) into a table-wide mask; indices wrap modulo DEPTH.
  function automatic logic [DEPTH-1:0] range_mask(input logic [ADDR_W-1:0] a,
                                                   input logic [1:0]        s);
    logic [DEPTH-1:0]  m;
    logic [3:0]        nwords;
    logic [ADDR_W-1:0] idx;
    m      = '0;
    nwords = 4'd1 << clamp_size(s);
    for (int unsigned k = 0; k < 8; k++) begin
      if (k < 32'(nwords)) begin
        idx    = a + ADDR_W'(k);
        m[idx] = 1'b1;
      end
    end
    return m;
  endfunction

  logic [DEPTH-1:0]   busy_q, busy_d;
  logic [NUM_CHK-1:0] chk_rsp_valid_q, chk_rsp_valid_d;
  logic [NUM_CHK-1:0] chk_ready_q, chk_ready_d;
  logic [ADDR_W:0]    busy_count_q, busy_count_d;
  logic               err_waw_q, err_waw_d;
  logic               err_ret_q, err_ret_d;

  logic [DEPTH-1:0]   ret_mask;
  logic [DEPTH-1:0]   iss_mask;

  // Next table state, check responses, occupancy and error detection.
  always_comb begin
    ret_mask = '0;
    for (int unsigned i = 0; i < NUM_RET; i++) begin
      if (ret_valid[i]) begin
        ret_mask = ret_mask | range_mask(ret_addr[i*ADDR_W +: ADDR_W], ret_size[i*2 +: 2]);
      end
    end

    iss_mask = '0;
    if (issue_valid) begin
      iss_mask = range_mask(issue_addr, issue_size);
    end

    // Set wins over clear on a bit touched by both in the same cycle.
    busy_d = (busy_q & ~ret_mask) | iss_mask;

    chk_rsp_valid_d = chk_valid;
    chk_ready_d     = '0;
    for (int unsigned j = 0; j < NUM_CHK; j++) begin
      if (chk_valid[j]) begin
        chk_ready_d[j] = ~|(busy_d & range_mask(chk_addr[j*ADDR_W +: ADDR_W], chk_size[j*2 +: 2]));
      end
    end

    busy_count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
    end

    // A bit retired and re-issued in the same cycle is a legal reuse.
    err_waw_d = err_waw_q | (|(iss_mask & busy_q & ~ret_mask));
    // Bits being issued this cycle never count as spurious retires.
    err_ret_d = err_ret_q | (|(ret_mask & ~busy_q & ~iss_mask));
  end

  // State registers with synchronous reset; inputs are ignored during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q          <= '0;
      chk_rsp_valid_q <= '0;
      chk_ready_q     <= '0;
      busy_count_q    <= '0;
      err_waw_q       <= 1'b0;
      err_ret_q       <= 1'b0;
    end else begin
      busy_q          <= busy_d;
      chk_rsp_valid_q <= chk_rsp_valid_d;
      chk_ready_q     <= chk_ready_d;
      busy_count_q    <= busy_count_d;
      err_waw_q       <= err_waw_d;
      err_ret_q       <= err_ret_d;
    end
  end

  assign chk_rsp_valid = chk_rsp_valid_q;
  assign chk_ready     = chk_ready_q;
  assign busy_count    = busy_count_q;
  assign err_waw       = err_waw_q;
  assign err_ret       = err_ret_q;

endmodule

// File: tb/tb_sgpr_busy_table.sv
// Directed self-checking bench for sgpr_busy_table (default parameters).
module tb_sgpr_busy_table;

  localparam int ADDR_W  = 9;
  localparam int NUM_RET = 2;
  localparam int NUM_CHK = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      issue_valid;
  logic [ADDR_W-1:0]         issue_addr;
  logic [1:0]                issue_size;
  logic [NUM_RET-1:0]        ret_valid;
  logic [NUM_RET*ADDR_W-1:0] ret_addr;
  logic [NUM_RET*2-1:0]      ret_size;
  logic [NUM_CHK-1:0]        chk_valid;
  logic [NUM_CHK*ADDR_W-1:0] chk_addr;
  logic [NUM_CHK*2-1:0]      chk_size;
  logic [NUM_CHK-1:0]        chk_rsp_valid;
  logic [NUM_CHK-1:0]        chk_ready;
  logic [ADDR_W:0]           busy_count;
  logic                      err_waw;
  logic                      err_ret;

  int passed = 0;
  int total  = 0;

  sgpr_busy_table #(
    .ADDR_W(ADDR_W), .MAX_LOG_WORDS(2), .NUM_RET(NUM_RET), .NUM_CHK(NUM_CHK)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_size(issue_size),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_size(ret_size),
    .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_size(chk_size),
    .chk_rsp_valid(chk_rsp_valid), .chk_ready(chk_ready),
    .busy_count(busy_count), .err_waw(err_waw), .err_ret(err_ret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_addr = '0; issue_size = '0;
    ret_valid   = '0;   ret_addr   = '0; ret_size   = '0;
    chk_valid   = '0;   chk_addr   = '0; chk_size   = '0;
  endtask

  task automatic do_issue(input logic [ADDR_W-1:0] a, input logic [1:0] s);
    issue_valid = 1'b1; issue_addr = a; issue_size = s;
  endtask

  task automatic do_ret(input int ch, input logic [ADDR_W-1:0] a, input logic [1:0] s);
    ret_valid[ch] = 1'b1;
    ret_addr[ch*ADDR_W +: ADDR_W] = a;
    ret_size[ch*2 +: 2] = s;
  endtask

  task automatic do_chk(input int ln, input logic [ADDR_W-1:0] a, input logic [1:0] s);
    chk_valid[ln] = 1'b1;
    chk_addr[ln*ADDR_W +: ADDR_W] = a;
    chk_size[ln*2 +: 2] = s;
  endtask

  initial begin
    clear_inputs();
    // Reset for two cycles with a stray issue that must be lost.
    rst = 1'b1;
    do_issue(9'h005, 2'd0);
    tick();
    tick();
    check("rst_count", 32'(busy_count), 32'd0);
    check("rst_rspv",  32'(chk_rsp_valid), 32'd0);
    check("rst_ready", 32'(chk_ready), 32'd0);
    check("rst_waw",   32'(err_waw), 32'd0);
    check("rst_ret",   32'(err_ret), 32'd0);
    rst = 1'b0;
    clear_inputs();

    // Idle check, oversize clamps to 4 words.
    do_chk(0, 9'h000, 2'd3);
    tick(); clear_inputs();
    check("idle_rspv",  32'(chk_rsp_valid), 32'h1);
    check("idle_ready", 32'(chk_ready), 32'h1);
    check("idle_count", 32'(busy_count), 32'd0);
    check("idle_waw",   32'(err_waw), 32'd0);
    check("idle_ret",   32'(err_ret), 32'd0);

    // Issue 0x010..0x013.
    do_issue(9'h010, 2'd2);
    tick(); clear_inputs();
    check("iss_count", 32'(busy_count), 32'd4);
    do_chk(1, 9'h013, 2'd0);
    do_chk(2, 9'h014, 2'd0);
    do_chk(3, 9'h00F, 2'd0);
    tick(); clear_inputs();
    check("iss_rspv",  32'(chk_rsp_valid), 32'hE);
    check("iss_ready", 32'(chk_ready), 32'hC);
    do_ret(0, 9'h010, 2'd2);
    tick(); clear_inputs();
    check("iss_ret_count", 32'(busy_count), 32'd0);
    check("iss_ret_err",   32'(err_ret), 32'd0);

    // Wrap-around: 0x1FF and 0x000.
    do_issue(9'h1FF, 2'd1);
    tick(); clear_inputs();
    check("wrap_count", 32'(busy_count), 32'd2);
    do_chk(0, 9'h000, 2'd0);
    do_chk(1, 9'h1FE, 2'd0);
    do_chk(2, 9'h1FC, 2'd2);
    tick(); clear_inputs();
    check("wrap_rspv",  32'(chk_rsp_valid), 32'h7);
    check("wrap_ready", 32'(chk_ready), 32'h2);
    do_ret(1, 9'h1FF, 2'd1);
    tick(); clear_inputs();
    check("wrap_ret_count", 32'(busy_count), 32'd0);
    check("wrap_ret_err",   32'(err_ret), 32'd0);

    // Clamping on issue and retire.
    do_issue(9'h060, 2'd3);
    tick(); clear_inputs();
    check("clamp_iss_count", 32'(busy_count), 32'd4);
    do_ret(0, 9'h060, 2'd3);
    tick(); clear_inputs();
    check("clamp_ret_count", 32'(busy_count), 32'd0);
    check("clamp_ret_err",   32'(err_ret), 32'd0);

    // Same-cycle retire, issue and check; overlapping retire channels.
    do_issue(9'h020, 2'd1);
    tick(); clear_inputs();
    check("same_pre_count", 32'(busy_count), 32'd2);
    do_ret(0, 9'h020, 2'd1);
    do_ret(1, 9'h021, 2'd0);
    do_issue(9'h021, 2'd0);
    do_chk(0, 9'h020, 2'd1);
    do_chk(1, 9'h020, 2'd0);
    tick(); clear_inputs();
    check("same_ready", 32'(chk_ready), 32'h2);
    check("same_count", 32'(busy_count), 32'd1);
    check("same_waw",   32'(err_waw), 32'd0);
    check("same_ret",   32'(err_ret), 32'd0);
    do_ret(0, 9'h021, 2'd0);
    tick(); clear_inputs();
    check("same_clean", 32'(busy_count), 32'd0);

    // WAW and spurious retire.
    do_issue(9'h030, 2'd0);
    tick();
    check("waw_first", 32'(err_waw), 32'd0);
    tick(); clear_inputs();
    check("waw_second", 32'(err_waw), 32'd1);
    check("waw_count",  32'(busy_count), 32'd1);
    check("ret_before", 32'(err_ret), 32'd0);
    do_ret(0, 9'h040, 2'd0);
    tick(); clear_inputs();
    check("ret_spur",   32'(err_ret), 32'd1);
    check("ret_count",  32'(busy_count), 32'd1);
    repeat (10) tick();
    check("sticky_waw",   32'(err_waw), 32'd1);
    check("sticky_ret",   32'(err_ret), 32'd1);
    check("sticky_count", 32'(busy_count), 32'd1);

    // Reset mid-operation with 6 bits busy.
    do_issue(9'h070, 2'd2);
    tick(); clear_inputs();
    do_issue(9'h080, 2'd0);
    tick(); clear_inputs();
    check("mid_count", 32'(busy_count), 32'd6);
    do_chk(0, 9'h070, 2'd0);
    tick(); clear_inputs();
    check("mid_rspv",  32'(chk_rsp_valid), 32'h1);
    check("mid_ready", 32'(chk_ready), 32'h0);
    rst = 1'b1;
    do_chk(0, 9'h070, 2'd0);
    tick(); clear_inputs();
    rst = 1'b0;
    check("mrst_count", 32'(busy_count), 32'd0);
    check("mrst_rspv",  32'(chk_rsp_valid), 32'h0);
    check("mrst_waw",   32'(err_waw), 32'd0);
    check("mrst_ret",   32'(err_ret), 32'd0);
    do_chk(0, 9'h070, 2'd2);
    do_chk(3, 9'h080, 2'd0);
    tick(); clear_inputs();
    check("post_rspv",  32'(chk_rsp_valid), 32'h9);
    check("post_ready", 32'(chk_ready), 32'h9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
